// File: rtl/read_line_fifo_pkg.sv
// Shared constants and helpers for the read-line FIFO: element count,
// element-index width and the 8-bit element-range type.
package read_line_fifo_pkg;
    localparam int RANGE_W        = 8;
    localparam int DEF_FULL_WIDTH = 512;
    localparam int DEF_WIDTH      = 64;
    localparam int ELEMS          = DEF_FULL_WIDTH / DEF_WIDTH;
    localparam int IDX_W          = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    typedef logic [RANGE_W-1:0] range_t;

    function automatic int elems_of(input int full_w, input int w);
        return full_w / w;
    endfunction

    function automatic int idx_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // End of the emitted range, never past the last element of a line.
    function automatic range_t clamp_end(input range_t bounds, input int elems);
        if (int'(bounds) > elems) return range_t'(elems);
        return bounds;
    endfunction
endpackage

// File: rtl/read_line_fifo_if.sv
// Line-in / element-out handshake bundle of the read-line FIFO.
interface read_line_fifo_if #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64
);
    import read_line_fifo_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FULL_WIDTH-1:0] in_data;
    range_t                in_base;
    range_t                in_bounds;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_base, in_bounds, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_base, in_bounds, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/read_line_fifo_store.sv
// Line storage: DEPTH lines with per-entry read pointer and end, one write
// port and an element read of the addressed entry at its current pointer.
module read_line_store
    import read_line_fifo_pkg::*;
#(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 2,
    parameter int MSB_FIRST  = 1,
    parameter int LINE_W     = 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [LINE_W-1:0]     waddr_i,
    input  logic [FULL_WIDTH-1:0] wdata_i,
    input  range_t                wstart_i,
    input  range_t                wend_i,
    input  logic                  adv_i,
    input  logic [LINE_W-1:0]     raddr_i,
    output logic [WIDTH-1:0]      rdata_o,
    output range_t                rptr_o,
    output range_t                rend_o
);
    localparam int ELEMS_L = elems_of(FULL_WIDTH, WIDTH);

    logic [FULL_WIDTH-1:0] line_q [DEPTH];
    range_t                ptr_q  [DEPTH];
    range_t                end_q  [DEPTH];
    logic [FULL_WIDTH-1:0] head_line;

    // Writes never target the entry being read, so both updates can coexist.
    always_ff @(posedge clk) begin
        if (we_i) begin
            line_q[waddr_i] <= wdata_i;
            ptr_q[waddr_i]  <= wstart_i;
            end_q[waddr_i]  <= wend_i;
        end
        if (adv_i) begin
            ptr_q[raddr_i] <= ptr_q[raddr_i] + 1'b1;
        end
    end

    assign head_line = line_q[raddr_i];
    assign rptr_o    = ptr_q[raddr_i];
    assign rend_o    = end_q[raddr_i];

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < ELEMS_L; i++) begin
            if (rptr_o == RANGE_W'(i)) begin
                rdata_o = (MSB_FIRST != 0) ? head_line[FULL_WIDTH-1-i*WIDTH -: WIDTH]
                                           : head_line[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/read_line_fifo.sv
// Accepts whole lines, keeps the non-empty ones in FIFO order and streams
// the elements [base, min(bounds, ELEMS)) of each, one per cycle.
module read_line_fifo
    import read_line_fifo_pkg::*;
#(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 2,
    parameter int MSB_FIRST  = 1
) (
    input logic              clk,
    input logic              rst,
    read_line_fifo_if.slave  bus
);
    localparam int ELEMS_L = elems_of(FULL_WIDTH, WIDTH);
    localparam int LINE_W  = idx_w_of(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [LINE_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    range_t            end_c, rptr, rend;
    logic              accept, we, adv, pop;

    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] p);
        if (DEPTH == 1) return '0;
        return p + 1'b1;
    endfunction

    assign bus.in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign end_c         = clamp_end(bus.in_bounds, ELEMS_L);
    assign accept        = bus.in_valid & bus.in_ready;
    // Empty ranges are accepted but never take a slot.
    assign we            = accept & (bus.in_base < end_c) & ~rst;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_last  = bus.out_valid & (rptr == rend - 1'b1);
    assign adv           = bus.out_valid & bus.out_ready & ~rst;
    assign pop           = adv & bus.out_last;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (we)  wr_d = next_line(wr_q);
        if (pop) rd_d = next_line(rd_q);
        case ({we, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    read_line_store #(
        .FULL_WIDTH (FULL_WIDTH),
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .MSB_FIRST  (MSB_FIRST),
        .LINE_W     (LINE_W)
    ) u_store (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (wr_q),
        .wdata_i  (bus.in_data),
        .wstart_i (bus.in_base),
        .wend_i   (end_c),
        .adv_i    (adv),
        .raddr_i  (rd_q),
        .rdata_o  (bus.out_data),
        .rptr_o   (rptr),
        .rend_o   (rend)
    );
endmodule

// File: tb/tb_read_line_fifo.sv
// Bench for read_line_fifo: directed scenarios plus random traffic against a
// queue-of-elements reference model.
module tb_read_line_fifo;
    import read_line_fifo_pkg::*;

    localparam int FW = 512;
    localparam int W  = 64;
    localparam int D  = 2;
    localparam int NE = FW / W;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } elem_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_line_fifo_if #(.FULL_WIDTH(FW), .WIDTH(W)) bus ();
    read_line_fifo_if #(.FULL_WIDTH(FW), .WIDTH(W)) bus_l ();

    read_line_fifo #(.FULL_WIDTH(FW), .WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut (
        .clk (clk), .rst (rst), .bus (bus));
    read_line_fifo #(.FULL_WIDTH(FW), .WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_l (
        .clk (clk), .rst (rst), .bus (bus_l));

    elem_t exp_q[$];
    int    lines = 0;
    int    compared = 0;
    int    mismatched = 0;
    bit    checking = 0;
    bit    accepted = 0;

    function automatic logic [W-1:0] elem_of(input logic [FW-1:0] d, input int i, input bit msb);
        if (msb) return d[FW-1-i*W -: W];
        return d[i*W +: W];
    endfunction

    // Line whose element i (element 0 at the top) holds first+i.
    function automatic logic [FW-1:0] ramp(input logic [7:0] first);
        logic [FW-1:0] d;
        d = '0;
        for (int i = 0; i < NE; i++) d[FW-1-i*W -: W] = W'(first) + W'(i);
        return d;
    endfunction

    function automatic logic [FW-1:0] rand_line();
        logic [FW-1:0] d;
        for (int i = 0; i < FW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [FW-1:0] d,
                        input logic [7:0] b, input logic [7:0] bnd, input logic ordy);
        bit    exp_rdy;
        elem_t fr;
        int    s, e;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_base   = b;
        bus.in_bounds = bnd;
        bus.out_ready = ordy;
        exp_rdy = (lines < D);
        if (checking) begin
            check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
                check("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
            end else begin
                check("out_last_idle", 64'(bus.out_last), 64'(0));
            end
        end
        @(posedge clk);
        accepted = 0;
        if (r) begin
            exp_q.delete();
            lines    = 0;
            checking = 1;
        end else begin
            if (ordy && exp_q.size() != 0) begin
                fr = exp_q.pop_front();
                if (fr.last) lines--;
            end
            if (v && exp_rdy) begin
                accepted = 1;
                s = int'(b);
                e = (int'(bnd) > NE) ? NE : int'(bnd);
                if (s < e) begin
                    for (int i = s; i < e; i++)
                        exp_q.push_back('{data: elem_of(d, i, 1'b1), last: (i == e - 1)});
                    lines++;
                end
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, '0, 8'd0, 8'd0, ordy);
    endtask

    initial begin
        int n;
        logic [FW-1:0] ld;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_base = '0; bus.in_bounds = '0; bus.out_ready = 1'b0;
        bus_l.in_valid = 1'b0; bus_l.in_data = '0; bus_l.in_base = '0; bus_l.in_bounds = '0;
        bus_l.out_ready = 1'b0;
        step(1'b1, 1'b0, '0, 8'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, '0, 8'd0, 8'd0, 1'b0);
        idle(1'b1);

        // LSB-first instance: element 0 sits in the low bits.
        ld = '0;
        ld[63:0] = 64'hA;
        ld[FW-1 -: W] = 64'hBB;
        @(negedge clk);
        check("lsb_reset_valid", 64'(bus_l.out_valid), 64'(0));
        check("lsb_reset_ready", 64'(bus_l.in_ready), 64'(1));
        bus_l.in_valid = 1'b1; bus_l.in_data = ld; bus_l.in_base = 8'd0; bus_l.in_bounds = 8'd1;
        @(negedge clk);
        bus_l.in_valid = 1'b0;
        check("lsb_valid", 64'(bus_l.out_valid), 64'(1));
        check("lsb_data", 64'(bus_l.out_data), 64'hA);
        check("lsb_last", 64'(bus_l.out_last), 64'(1));
        bus_l.out_ready = 1'b1;
        @(negedge clk);
        check("lsb_drained", 64'(bus_l.out_valid), 64'(0));
        bus_l.out_ready = 1'b0;

        // Range 2..4 of a 0x10 ramp.
        step(1'b0, 1'b1, ramp(8'h10), 8'd2, 8'd5, 1'b1);
        repeat (5) idle(1'b1);
        // Clamped end, then an empty range.
        step(1'b0, 1'b1, ramp(8'h20), 8'd6, 8'd20, 1'b1);
        repeat (4) idle(1'b1);
        step(1'b0, 1'b1, ramp(8'h30), 8'd5, 8'd5, 1'b1);
        repeat (2) idle(1'b1);
        step(1'b0, 1'b1, ramp(8'h38), 8'd9, 8'd12, 1'b1);
        repeat (2) idle(1'b1);

        // Back-pressure: third line waits for the first to drain.
        step(1'b0, 1'b1, ramp(8'h40), 8'd0, 8'd8, 1'b0);
        step(1'b0, 1'b1, ramp(8'h50), 8'd0, 8'd8, 1'b0);
        n = 0;
        accepted = 0;
        while (!accepted && n < 40) begin
            step(1'b0, 1'b1, ramp(8'h60), 8'd0, 8'd8, n >= 2);
            n++;
        end
        check("third_accept", 64'(accepted), 64'(1));
        repeat (20) idle(1'b1);

        // Alternating consumer stalls over a full line.
        step(1'b0, 1'b1, ramp(8'h70), 8'd0, 8'd8, 1'b0);
        for (int i = 0; i < 16; i++) idle(i % 2 == 0);
        repeat (4) idle(1'b1);

        // Reset mid-line, then a fresh line from its own base.
        step(1'b0, 1'b1, ramp(8'h80), 8'd0, 8'd8, 1'b1);
        repeat (3) idle(1'b1);
        step(1'b1, 1'b0, '0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 1'b1, ramp(8'h90), 8'd3, 8'd6, 1'b1);
        repeat (5) idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), rand_line(),
                 8'($urandom_range(0, 9)), 8'($urandom_range(0, 12)),
                 $urandom_range(0, 3) != 0);
        end
        repeat (24) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
